// File: rtl/count3_sequencer.sv
// ============================================================================
//  Module   : count3_sequencer
//  Purpose  : Programmable up/down counter sequencer with terminal limit,
//             clock-enable prescaler, wrap repeat count and event pulses.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module count3_sequencer #(
   parameter int WIDTH = 3,
   parameter int PS_W  = 4,
   parameter int REP_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             up_dn,
   input  logic [WIDTH-1:0] lim,
   input  logic [PS_W-1:0]  prescale,
   input  logic [REP_W-1:0] reps,
   output logic [WIDTH-1:0] a,
   output logic             busy,
   output logic             tick,
   output logic             wrap,
   output logic             done
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t             state, state_nx;
   logic [WIDTH-1:0]   a_nx;
   logic               busy_nx, tick_nx, wrap_nx, done_nx;
   logic [PS_W-1:0]    ps_cnt, ps_cnt_nx;
   logic [REP_W-1:0]   wrap_cnt, wrap_cnt_nx;
   logic               cfg_up, cfg_up_nx;
   logic [WIDTH-1:0]   cfg_lim, cfg_lim_nx;
   logic [PS_W-1:0]    cfg_ps, cfg_ps_nx;
   logic [REP_W-1:0]   cfg_reps, cfg_reps_nx;
   logic               is_wrap;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         a        <= '0;
         busy     <= 1'b0;
         tick     <= 1'b0;
         wrap     <= 1'b0;
         done     <= 1'b0;
         ps_cnt   <= '0;
         wrap_cnt <= '0;
         cfg_up   <= 1'b0;
         cfg_lim  <= '0;
         cfg_ps   <= '0;
         cfg_reps <= '0;
      end else begin
         state    <= state_nx;
         a        <= a_nx;
         busy     <= busy_nx;
         tick     <= tick_nx;
         wrap     <= wrap_nx;
         done     <= done_nx;
         ps_cnt   <= ps_cnt_nx;
         wrap_cnt <= wrap_cnt_nx;
         cfg_up   <= cfg_up_nx;
         cfg_lim  <= cfg_lim_nx;
         cfg_ps   <= cfg_ps_nx;
         cfg_reps <= cfg_reps_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      a_nx        = a;
      tick_nx     = 1'b0;
      wrap_nx     = 1'b0;
      done_nx     = 1'b0;
      ps_cnt_nx   = ps_cnt;
      wrap_cnt_nx = wrap_cnt;
      cfg_up_nx   = cfg_up;
      cfg_lim_nx  = cfg_lim;
      cfg_ps_nx   = cfg_ps;
      cfg_reps_nx = cfg_reps;
      is_wrap     = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               state_nx    = RUN;
               cfg_up_nx   = up_dn;
               cfg_lim_nx  = lim;
               cfg_ps_nx   = prescale;
               cfg_reps_nx = reps;
               a_nx        = up_dn ? '0 : lim;
               ps_cnt_nx   = '0;
               wrap_cnt_nx = '0;
            end
         end
         RUN: begin
            // stop wins over a step falling on the same edge
            if (stop) begin
               state_nx = IDLE;
            end else if (ps_cnt == cfg_ps) begin
               ps_cnt_nx = '0;
               tick_nx   = 1'b1;
               if (cfg_up) begin
                  is_wrap = (a == cfg_lim);
                  a_nx    = is_wrap ? '0 : a + 1'b1;
               end else begin
                  is_wrap = (a == '0);
                  a_nx    = is_wrap ? cfg_lim : a - 1'b1;
               end
               if (is_wrap) begin
                  wrap_nx     = 1'b1;
                  wrap_cnt_nx = wrap_cnt + 1'b1;
                  if ((cfg_reps != '0) && (wrap_cnt_nx == cfg_reps)) begin
                     done_nx  = 1'b1;
                     state_nx = IDLE;
                  end
               end
            end else begin
               ps_cnt_nx = ps_cnt + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase

      busy_nx = (state_nx == RUN);
   end

endmodule

`default_nettype wire

// File: tb/tb_count3_sequencer.sv
// Directed vector bench for count3_sequencer: table-driven runs plus
// hand-written sequences for free-running, mid-run control and async reset.
`default_nettype none

module tb_count3_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0, stop = 1'b0, up_dn = 1'b0;
   logic [2:0] lim = '0;
   logic [3:0] prescale = '0, reps = '0;
   logic [2:0] a;
   logic       busy, tick, wrap, done;

   int total = 0;
   int bad   = 0;

   count3_sequencer #(.WIDTH(3), .PS_W(4), .REP_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .up_dn(up_dn),
      .lim(lim), .prescale(prescale), .reps(reps),
      .a(a), .busy(busy), .tick(tick), .wrap(wrap), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       s, p, ud;
      logic [2:0] l;
      logic [3:0] ps, r;
      logic [2:0] ea;
      logic       eb, et, ew, ed;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic s, p, ud, input logic [2:0] l,
                      input logic [3:0] ps, r, input logic [2:0] ea,
                      input logic eb, et, ew, ed);
      vec_t v;
      v.s = s; v.p = p; v.ud = ud; v.l = l; v.ps = ps; v.r = r;
      v.ea = ea; v.eb = eb; v.et = et; v.ew = ew; v.ed = ed;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [2:0] ea,
                          input logic eb, et, ew, ed);
      chk({tag, ".a"},    int'(a),    int'(ea));
      chk({tag, ".busy"}, int'(busy), int'(eb));
      chk({tag, ".tick"}, int'(tick), int'(et));
      chk({tag, ".wrap"}, int'(wrap), int'(ew));
      chk({tag, ".done"}, int'(done), int'(ed));
   endtask

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic s, p, ud, input logic [2:0] l,
                         input logic [3:0] ps, r);
      start = s; stop = p; up_dn = ud; lim = l; prescale = ps; reps = r;
   endtask

   initial begin
      logic [2:0] ea;

      // ---------------- reset ----------------
      #1 rst = 1'b0;
      #7;
      chk_all("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      #4 rst = 1'b1;

      // ---------------- table ----------------
      // up run: lim=5, prescale=0, reps=2
      add(1, 0, 1, 3'd5, 4'd0, 4'd2, 3'd0, 1, 0, 0, 0);
      for (int i = 1; i <= 12; i++)
         add(0, 0, 0, 3'd0, 4'd0, 4'd0, 3'(i % 6), (i != 12), 1,
             (i % 6 == 0), (i == 12));
      add(0, 0, 0, 3'd0, 4'd0, 4'd0, 3'd0, 0, 0, 0, 0);
      // stop in IDLE is ignored
      add(0, 1, 0, 3'd0, 4'd0, 4'd0, 3'd0, 0, 0, 0, 0);
      // down run with coincident stop on the start edge: lim=3, prescale=1, reps=1
      add(1, 1, 0, 3'd3, 4'd1, 4'd1, 3'd3, 1, 0, 0, 0);
      add(0, 0, 0, 3'd0, 4'd0, 4'd0, 3'd3, 1, 0, 0, 0);
      add(0, 0, 0, 3'd0, 4'd0, 4'd0, 3'd2, 1, 1, 0, 0);
      add(0, 0, 0, 3'd0, 4'd0, 4'd0, 3'd2, 1, 0, 0, 0);
      add(0, 0, 0, 3'd0, 4'd0, 4'd0, 3'd1, 1, 1, 0, 0);
      add(0, 0, 0, 3'd0, 4'd0, 4'd0, 3'd1, 1, 0, 0, 0);
      add(0, 0, 0, 3'd0, 4'd0, 4'd0, 3'd0, 1, 1, 0, 0);
      add(0, 0, 0, 3'd0, 4'd0, 4'd0, 3'd0, 1, 0, 0, 0);
      add(0, 0, 0, 3'd0, 4'd0, 4'd0, 3'd3, 0, 1, 1, 1);
      add(0, 0, 0, 3'd0, 4'd0, 4'd0, 3'd3, 0, 0, 0, 0);

      foreach (vq[i]) begin
         set_in(vq[i].s, vq[i].p, vq[i].ud, vq[i].l, vq[i].ps, vq[i].r);
         edge1();
         chk_all($sformatf("vec%0d", i), vq[i].ea, vq[i].eb, vq[i].et,
                 vq[i].ew, vq[i].ed);
      end

      // ---------------- free run, reps=0, then stop at a=4 ----------------
      set_in(1, 0, 1, 3'd7, 4'd0, 4'd0);
      edge1();
      chk_all("free.start", 3'd0, 1, 0, 0, 0);
      set_in(0, 0, 0, 3'd0, 4'd0, 4'd0);
      for (int i = 1; i <= 44; i++) begin
         edge1();
         ea = 3'(i % 8);
         chk_all($sformatf("free%0d", i), ea, 1, 1, (ea == 3'd0), 0);
      end
      stop = 1'b1;
      edge1();
      chk_all("free.stop", 3'd4, 0, 0, 0, 0);
      stop = 1'b0;
      edge1();
      chk_all("free.idle", 3'd4, 0, 0, 0, 0);

      // ---------------- mid-run start and lim change ignored ----------------
      set_in(1, 0, 1, 3'd6, 4'd0, 4'd1);
      edge1();
      chk_all("mid.start", 3'd0, 1, 0, 0, 0);
      set_in(1, 0, 0, 3'd2, 4'd3, 4'd0);
      edge1();
      chk_all("mid1", 3'd1, 1, 1, 0, 0);
      start = 1'b0;
      for (int i = 2; i <= 7; i++) begin
         edge1();
         ea = 3'(i % 7);
         chk_all($sformatf("mid%0d", i), ea, (i != 7), 1, (i == 7), (i == 7));
      end

      // ---------------- async reset mid-run ----------------
      set_in(1, 0, 1, 3'd5, 4'd0, 4'd0);
      edge1();
      start = 1'b0;
      for (int i = 0; i < 3; i++) edge1();
      chk_all("rst.pre", 3'd3, 1, 1, 0, 0);
      #2 rst = 1'b0;
      #1;
      chk_all("rst.async", 3'd0, 0, 0, 0, 0);
      edge1();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         edge1();
         chk_all($sformatf("rst.idle%0d", i), 3'd0, 0, 0, 0, 0);
      end

      // ---------------- lim=0, reps=3 ----------------
      set_in(1, 0, 1, 3'd0, 4'd0, 4'd3);
      edge1();
      chk_all("lim0.start", 3'd0, 1, 0, 0, 0);
      start = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         edge1();
         chk_all($sformatf("lim0.%0d", i), 3'd0, (i != 3), 1, 1, (i == 3));
      end
      edge1();
      chk_all("lim0.after", 3'd0, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
